// File: rtl/ttag_ctrl.sv
// Tag RAM write controller: arbitrates fill/prefetch tag installs between two
// requesters and runs a full invalidate sweep after reset or on flush_all.
module ttag_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int WAYS       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_all,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [43:0]           req0_IP,
  input  logic [1:0]            req0_way,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [43:0]           req1_IP,
  input  logic [1:0]            req1_way,
  output logic                  ram_wen,
  output logic                  ram_all_ways,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [1:0]            ram_way,
  output logic [43:0]           ram_IP,
  output logic                  ram_valid,
  output logic                  doStall,
  output logic                  flush_done
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ram_wen_q, ram_wen_d;
  logic                  ram_all_ways_q, ram_all_ways_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [1:0]            ram_way_q, ram_way_d;
  logic [43:0]           ram_ip_q, ram_ip_d;
  logic                  ram_valid_q, ram_valid_d;
  logic                  flush_done_q, flush_done_d;
  logic                  prio_q, prio_d;  // 1: requester 1 wins a tie
  logic [4:0]            lfsr_q, lfsr_d;

  logic        grant0, grant1;
  logic [43:0] sel_ip;
  logic [1:0]  sel_way;
  logic [1:0]  repl_way;

  // Flush owns the RAM port; no request is accepted while flushing or when a
  // flush is being requested.
  assign grant0 = (state_q == IDLE) && !flush_all && req0_valid &&
                  (!req1_valid || !prio_q);
  assign grant1 = (state_q == IDLE) && !flush_all && req1_valid &&
                  (!req0_valid || prio_q);

  assign sel_ip   = grant1 ? req1_IP  : req0_IP;
  assign sel_way  = grant1 ? req1_way : req0_way;
  assign repl_way = (int'(lfsr_q[1:0]) >= WAYS) ? 2'd0 : lfsr_q[1:0];

  // NOTE: every always_comb target gets a default first, otherwise a path
  // that skips the assignment infers a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ram_wen_d      = 1'b0;
    ram_all_ways_d = 1'b0;
    ram_addr_d     = ram_addr_q;
    ram_way_d      = ram_way_q;
    ram_ip_d       = ram_ip_q;
    ram_valid_d    = ram_valid_q;
    flush_done_d   = 1'b0;
    prio_d         = prio_q;
    lfsr_d         = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};

    if (state_q == FLUSH) begin
      ram_wen_d      = 1'b1;
      ram_all_ways_d = 1'b1;
      ram_valid_d    = 1'b0;
      ram_addr_d     = cnt_q;
      ram_ip_d       = '0;
      cnt_d          = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d      = IDLE;
        flush_done_d = 1'b1;
      end
    end else if (grant0 || grant1) begin
      ram_wen_d      = 1'b1;
      ram_all_ways_d = 1'b0;
      ram_valid_d    = 1'b1;
      ram_addr_d     = sel_ip[ADDR_WIDTH+6:7];
      ram_way_d      = (int'(sel_way) < WAYS) ? sel_way : repl_way;
      ram_ip_d       = sel_ip;
      prio_d         = grant0;
    end

    // A new flush request restarts the sweep and suppresses a pending done.
    if (flush_all) begin
      state_d      = FLUSH;
      cnt_d        = '0;
      flush_done_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the tag RAM itself has no reset; resetting into FLUSH makes the
  // controller invalidate every set before fetch may read it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FLUSH;
      cnt_q          <= '0;
      ram_wen_q      <= 1'b0;
      ram_all_ways_q <= 1'b0;
      ram_addr_q     <= '0;
      ram_way_q      <= '0;
      ram_ip_q       <= '0;
      ram_valid_q    <= 1'b0;
      flush_done_q   <= 1'b0;
      prio_q         <= 1'b0;
      lfsr_q         <= 5'b00001;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ram_wen_q      <= ram_wen_d;
      ram_all_ways_q <= ram_all_ways_d;
      ram_addr_q     <= ram_addr_d;
      ram_way_q      <= ram_way_d;
      ram_ip_q       <= ram_ip_d;
      ram_valid_q    <= ram_valid_d;
      flush_done_q   <= flush_done_d;
      prio_q         <= prio_d;
      lfsr_q         <= lfsr_d;
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign ram_wen      = ram_wen_q;
  assign ram_all_ways = ram_all_ways_q;
  assign ram_addr     = ram_addr_q;
  assign ram_way      = ram_way_q;
  assign ram_IP       = ram_ip_q;
  assign ram_valid    = ram_valid_q;
  assign flush_done   = flush_done_q;
  assign doStall      = (state_q == FLUSH) || flush_all;

endmodule

// File: tb/tb_ttag_ctrl.sv
// Directed bench for ttag_ctrl: scoreboard of expected tag writes, reference
// LFSR and round-robin model, flush sweeps checked set by set.
module tb_ttag_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_all;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [43:0] req0_IP, req1_IP;
  logic [1:0]  req0_way, req1_way;
  logic        ram_wen, ram_all_ways, ram_valid, doStall, flush_done;
  logic [6:0]  ram_addr;
  logic [1:0]  ram_way;
  logic [43:0] ram_IP;

  ttag_ctrl #(.ADDR_WIDTH(7), .WAYS(3)) dut (
    .clk(clk), .rst(rst), .flush_all(flush_all),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_IP(req0_IP), .req0_way(req0_way),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_IP(req1_IP), .req1_way(req1_way),
    .ram_wen(ram_wen), .ram_all_ways(ram_all_ways), .ram_addr(ram_addr), .ram_way(ram_way),
    .ram_IP(ram_IP), .ram_valid(ram_valid), .doStall(doStall), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic [1:0]  way;
    logic [43:0] ip;
  } wr_t;

  wr_t         sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [4:0]  lfsr_m;
  logic        prio_m;
  logic        idle_m;
  logic [43:0] last_ip;
  logic        last_g0, last_g1;

  // Reference replacement LFSR, x^5+x^3+1, advancing every cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 5'b00001;
    else     lfsr_m <= {lfsr_m[3:0], lfsr_m[4] ^ lfsr_m[2]};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_way(input logic [1:0] req_way);
    if (req_way < 2'd3) return req_way;
    return (lfsr_m[1:0] == 2'd3) ? 2'd0 : lfsr_m[1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ram();
    wr_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ram_write", {ram_wen, ram_all_ways, ram_valid, ram_addr, ram_way, ram_IP},
            {1'b1, 1'b0, 1'b1, e.addr, e.way, e.ip});
      last_ip = e.ip;
    end else begin
      check("ram_quiet", {ram_wen, ram_all_ways, flush_done, ram_IP}, {3'b000, last_ip});
    end
  endtask

  task automatic step_req(input logic v0, input logic [43:0] ip0, input logic [1:0] w0,
                          input logic v1, input logic [43:0] ip1, input logic [1:0] w1,
                          input logic fl);
    wr_t e;
    req0_valid = v0; req0_IP = ip0; req0_way = w0;
    req1_valid = v1; req1_IP = ip1; req1_way = w1;
    flush_all  = fl;
    #1;
    last_g0 = idle_m && !fl && v0 && (!v1 || !prio_m);
    last_g1 = idle_m && !fl && v1 && (!v0 || prio_m);
    check("ready", {req0_ready, req1_ready}, {last_g0, last_g1});
    check("stall", doStall, fl || !idle_m);
    if (last_g0) begin
      e.addr = ip0[13:7]; e.way = exp_way(w0); e.ip = ip0;
      sb.push_back(e);
      prio_m = 1'b1;
    end else if (last_g1) begin
      e.addr = ip1[13:7]; e.way = exp_way(w1); e.ip = ip1;
      sb.push_back(e);
      prio_m = 1'b0;
    end
    tick();
    check_ram();
    if (fl) idle_m = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; flush_all = 1'b0;
  endtask

  // Walks n sweep cycles starting at set 0; done is expected on set 127.
  task automatic run_flush(input int n);
    logic [6:0] a;
    for (int i = 0; i < n; i++) begin
      check("flush_ready", {req0_ready, req1_ready}, 2'b00);
      tick();
      a = 7'(i);
      check("flush_sweep", {ram_wen, ram_all_ways, ram_valid, ram_addr, flush_done, doStall},
            {1'b1, 1'b1, 1'b0, a, (i == 127), (i != 127)});
    end
    if (n == 128) begin
      idle_m  = 1'b1;
      last_ip = '0;
    end
  endtask

  logic [43:0] ip0_tab[3];
  logic [43:0] ip1_tab[3];
  logic [43:0] rnd_ip;
  int          i0, i1;

  initial begin
    rst = 1'b1; flush_all = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_IP = '0; req1_IP = '0; req0_way = '0; req1_way = '0;
    prio_m = 1'b0; idle_m = 1'b0; last_ip = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {ram_wen, ram_all_ways, ram_valid, ram_addr, ram_way, ram_IP, flush_done}, '0);
    check("rst_stall", doStall, 1'b1);
    @(negedge clk) rst = 1'b0;

    // Power-on flush sweep
    run_flush(128);
    step_req(0, '0, 0, 0, '0, 0, 0);

    // Both requesters contend for four cycles: 0,1,0,1
    ip0_tab[0] = 44'h0AB_0000_0080; ip0_tab[1] = 44'h0CD_1111_3F80; ip0_tab[2] = 44'h000_0000_0000;
    ip1_tab[0] = 44'hFFF_FFFF_FF80; ip1_tab[1] = 44'h555_AAAA_5500; ip1_tab[2] = 44'h000_0000_0000;
    i0 = 0; i1 = 0;
    for (int k = 0; k < 4; k++) begin
      step_req(1, ip0_tab[i0], 2'd2, 1, ip1_tab[i1], 2'd0, 0);
      check("rr_order", {last_g0, last_g1}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (last_g0) i0++;
      if (last_g1) i1++;
    end

    // Single fill with explicit way
    step_req(1, 44'h123_4567_8980, 2'd1, 0, '0, 0, 0);
    check("fill_addr_way", {ram_addr, ram_way}, {7'h13, 2'd1});

    // Quiet cycle holds fields, then lone requesters
    step_req(0, '0, 0, 0, '0, 0, 0);
    step_req(0, '0, 0, 1, 44'h321_0000_1F80, 2'd2, 0);
    step_req(1, 44'h001_0203_0400, 2'd0, 0, '0, 0, 0);
    step_req(0, '0, 0, 0, '0, 0, 0);

    // Replacement way chosen by LFSR
    for (int k = 0; k < 6; k++) begin
      rnd_ip = {12'($urandom), 32'($urandom)};
      if (k % 2 == 0) step_req(1, rnd_ip, 2'd3, 0, '0, 0, 0);
      else            step_req(0, '0, 0, 1, rnd_ip, 2'd3, 0);
      check("repl_not3", {62'd0, ram_way == 2'd3}, 64'd0);
    end

    // Write registered just before flush_all, then flush with a request pending
    step_req(1, 44'h0F0_0F0F_0F00, 2'd2, 0, '0, 0, 0);
    step_req(1, 44'h777_7777_7700, 2'd1, 0, '0, 0, 1);
    run_flush(60);
    req0_valid = 1'b1; req0_IP = 44'h777_7777_7700; req0_way = 2'd1;
    flush_all  = 1'b1;
    #1;
    check("abort_ready", {req0_ready, req1_ready}, 2'b00);
    tick();
    check("abort_no_done", {flush_done, doStall}, 2'b01);
    flush_all = 1'b0;
    run_flush(128);
    step_req(1, 44'h777_7777_7700, 2'd1, 0, '0, 0, 0);

    // Asynchronous reset in the middle of write traffic
    step_req(1, 44'h246_8ACE_1300, 2'd0, 0, '0, 0, 0);
    req0_valid = 1'b1; req0_IP = 44'h135_7913_5780; req0_way = 2'd2;
    #1;
    check("pre_rst_ready", {req0_ready, req1_ready}, 2'b10);
    rst = 1'b1;
    #1;
    check("async_rst", {ram_wen, ram_all_ways, ram_valid, ram_addr, ram_way, ram_IP, flush_done}, '0);
    check("async_rst_ctl", {req0_ready, doStall}, 2'b01);
    sb.delete();
    prio_m = 1'b0; idle_m = 1'b0; last_ip = '0;
    req0_valid = 1'b0;
    tick();
    check("rst_hold", {ram_wen, ram_IP, flush_done, doStall}, {1'b0, 44'd0, 1'b0, 1'b1});
    @(negedge clk) rst = 1'b0;
    run_flush(128);

    // Pointer and LFSR restarted by reset
    step_req(1, 44'h0AA_0000_1200, 2'd3, 1, 44'h0BB_0000_3400, 2'd3, 0);
    check("rst_prio", {last_g0, last_g1}, 2'b10);
    step_req(1, 44'h0AA_0000_1200, 2'd3, 1, 44'h0BB_0000_3400, 2'd3, 0);
    step_req(0, '0, 0, 0, '0, 0, 0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
